// File: rtl/imem_prog_loader.sv
// Byte-stream program loader: assembles 3-byte little-endian words into instruction memory,
// holding the CPU in reset until the load completes. Optional trailer check: IMEM_LOADER_CHECKSUM_EN.
module imem_prog_loader #(
    parameter int ADDR_W = 12,
    parameter int INST_W = 19,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [INST_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              cpu_start,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int IDX_W = ADDR_W + 1;
    localparam int unsigned DEPTH_U = DEPTH;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_B0,
        S_B1,
        S_B2,
        S_WRITE,
        S_START,
        S_DONE,
        S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CSUM;
`else
    localparam state_t S_TAIL = S_START;
`endif

    state_t             state_q, state_d;
    logic [15:0]        len_q, len_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [15:0]        asm_q, asm_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INST_W-1:0]  wdata_q, wdata_d;

    logic               xfer;
    logic [15:0]        n_full;
    logic [23:0]        word_full;

    assign xfer      = byte_valid && byte_ready;
    assign n_full    = {byte_data, len_q[7:0]};
    assign word_full = {byte_data, asm_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            asm_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    // Cleared at load start; every accepted byte except the trailer itself folds in.
    always_comb begin
        csum_d = csum_q;
        if ((state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR) && load_req)
            csum_d = '0;
        else if (xfer && state_q != S_CSUM)
            csum_d = csum_q ^ byte_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) csum_q <= '0;
        else      csum_q <= csum_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (load_req) state_d = S_HDR0;
            end
            S_HDR0: begin
                if (xfer) begin
                    len_d[7:0] = byte_data;
                    state_d    = S_HDR1;
                end
            end
            S_HDR1: begin
                if (xfer) begin
                    len_d = n_full;
                    idx_d = '0;
                    if (n_full == 16'd0)               state_d = S_TAIL;
                    else if (32'(n_full) > DEPTH_U)    state_d = S_ERR;
                    else                               state_d = S_B0;
                end
            end
            S_B0: begin
                if (xfer) begin
                    asm_d[7:0] = byte_data;
                    state_d    = S_B1;
                end
            end
            S_B1: begin
                if (xfer) begin
                    asm_d[15:8] = byte_data;
                    state_d     = S_B2;
                end
            end
            S_B2: begin
                // Address and word are registered here so they stay put after the write.
                if (xfer) begin
                    wdata_d = word_full[INST_W-1:0];
                    addr_d  = idx_q[ADDR_W-1:0];
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (16'(idx_q) == len_q - 16'd1) begin
                    state_d = S_TAIL;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_B0;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) state_d = (byte_data == csum_q) ? S_START : S_ERR;
            end
`endif
            S_START: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        cpu_start  = 1'b0;
        cpu_hold   = 1'b1;
        busy       = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        imem_addr  = addr_q;
        imem_wdata = wdata_q;
        case (state_q)
            S_HDR0, S_HDR1, S_B0, S_B1, S_B2: byte_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM:  byte_ready = 1'b1;
`endif
            S_WRITE: imem_we = 1'b1;
            S_START: begin
                cpu_start = 1'b1;
                cpu_hold  = 1'b0;
            end
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                busy     = 1'b0;
            end
            S_ERR: begin
                err  = 1'b1;
                busy = 1'b0;
            end
            S_IDLE:  busy = 1'b0;
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_imem_prog_loader.sv
// Directed bench for imem_prog_loader: expected writes queued as bytes are sent, checked as imem_we fires.
module tb_imem_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_req = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready, imem_we, cpu_hold, cpu_start, busy, done, err;
    logic [11:0] imem_addr;
    logic [18:0] imem_wdata;

    imem_prog_loader #(.ADDR_W(12), .INST_W(19), .DEPTH(4096)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_req   (load_req),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .cpu_start  (cpu_start),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] a;
        logic [18:0] d;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         got;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          we_cnt = 0;
    int          start_cnt = 0;
    int          last_we_cyc = 0;
    int          prev_we_cyc = 0;
    int          start_cyc = 0;
    logic [11:0] last_we_addr = '0;
    logic [7:0]  tb_xor = '0;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int START_GAP = 2;
`else
    localparam int START_GAP = 1;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (imem_we) begin
            we_cnt++;
            prev_we_cyc  = last_we_cyc;
            last_we_cyc  = cyc;
            last_we_addr = imem_addr;
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_write observed addr=0x%0h data=0x%0h expected no write", imem_addr, imem_wdata);
            end
            if (exp_q.size() != 0) begin
                got = exp_q.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(got.a));
                check("wr_data", 32'(imem_wdata), 32'(got.d));
            end
        end
        if (cpu_start) begin
            start_cnt++;
            start_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        bit ok = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        tb_xor     = tb_xor ^ b;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (byte_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        check("xfer_accepted", 32'(ok), 32'd1);
    endtask

    task automatic gap();
        byte_valid = 1'b0;
        byte_data  = 8'hA5;
        tick();
    endtask

    task automatic push(input logic [11:0] a, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        wr_t e;
        e.a = a;
        e.d = {b2[2:0], b1, b0};
        exp_q.push_back(e);
    endtask

    task automatic send_csum();
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] c;
        c = tb_xor;
        send(c);
`endif
    endtask

    task automatic wait_start();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (cpu_start) seen = 1'b1;
        end
        @(posedge clk);
        #1;
        check("start_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        check("rst_ready", 32'(byte_ready), 32'd0);
        check("rst_we",    32'(imem_we),    32'd0);
        check("rst_hold",  32'(cpu_hold),   32'd1);
        check("rst_start", 32'(cpu_start),  32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_done",  32'(done),       32'd0);
        check("rst_err",   32'(err),        32'd0);
        check("rst_addr",  32'(imem_addr),  32'd0);
        check("rst_wdata", 32'(imem_wdata), 32'd0);
        rst = 1'b1;
        tick();

        // Basic back-to-back load
        tb_xor = '0;
        pulse_load();
        check("hdr0_busy",  32'(busy),       32'd1);
        check("hdr0_hold",  32'(cpu_hold),   32'd1);
        check("hdr0_ready", 32'(byte_ready), 32'd1);
        send(8'h02); send(8'h00);
        push(12'd0, 8'h34, 8'h12, 8'h05);
        push(12'd1, 8'hFF, 8'hFF, 8'h7F);
        send(8'h34); send(8'h12); send(8'h05);
        send(8'hFF); send(8'hFF); send(8'h7F);
        send_csum();
        byte_valid = 1'b0;
        wait_start();
        check("basic_we_cnt",    32'(we_cnt), 32'd2);
        check("basic_word_gap",  32'(last_we_cyc - prev_we_cyc), 32'd4);
        check("basic_start_gap", 32'(start_cyc - last_we_cyc), 32'(START_GAP));
        check("basic_start_cnt", 32'(start_cnt), 32'd1);
        check("basic_done",      32'(done), 32'd1);
        check("basic_hold",      32'(cpu_hold), 32'd0);
        check("basic_busy",      32'(busy), 32'd0);
        check("basic_addr_hold", 32'(imem_addr), 32'd1);
        check("basic_q_empty",   32'(exp_q.size()), 32'd0);

        // Reload from DONE with throttled valid and a load_req while busy
        tb_xor = '0;
        pulse_load();
        check("reload_done_clr", 32'(done), 32'd0);
        check("reload_hold",     32'(cpu_hold), 32'd1);
        send(8'h02); gap(); send(8'h00); gap();
        push(12'd0, 8'h34, 8'h12, 8'h05);
        push(12'd1, 8'hFF, 8'hFF, 8'h7F);
        send(8'h34); gap(); send(8'h12);
        byte_valid = 1'b0;
        pulse_load();
        check("busy_ignore_load", 32'(busy), 32'd1);
        send(8'h05); gap(); send(8'hFF); gap(); send(8'hFF); gap(); send(8'h7F); gap();
        send_csum();
        byte_valid = 1'b0;
        wait_start();
        check("thr_we_cnt",    32'(we_cnt), 32'd4);
        check("thr_start_cnt", 32'(start_cnt), 32'd2);
        check("thr_done",      32'(done), 32'd1);

        // N = 0
        tb_xor = '0;
        pulse_load();
        send(8'h00); send(8'h00);
        send_csum();
        byte_valid = 1'b0;
        wait_start();
        check("n0_we_cnt",    32'(we_cnt), 32'd4);
        check("n0_start_cnt", 32'(start_cnt), 32'd3);
        check("n0_done",      32'(done), 32'd1);

        // N = 4097 is rejected
        tb_xor = '0;
        pulse_load();
        send(8'h01); send(8'h10);
        byte_valid = 1'b0;
        tick(); tick();
        check("nbig_err",       32'(err), 32'd1);
        check("nbig_hold",      32'(cpu_hold), 32'd1);
        check("nbig_done",      32'(done), 32'd0);
        check("nbig_busy",      32'(busy), 32'd0);
        check("nbig_ready",     32'(byte_ready), 32'd0);
        check("nbig_start_cnt", 32'(start_cnt), 32'd3);

        // N = 4096 fills memory exactly
        tb_xor = '0;
        pulse_load();
        check("full_err_clr", 32'(err), 32'd0);
        send(8'h00); send(8'h10);
        for (int a = 0; a < 4096; a++) begin
            logic [7:0] b0, b1, b2;
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            push(12'(a), b0, b1, b2);
            send(b0); send(b1); send(b2);
        end
        send_csum();
        byte_valid = 1'b0;
        wait_start();
        check("full_last_addr", 32'(last_we_addr), 32'hFFF);
        check("full_we_cnt",    32'(we_cnt), 32'd4100);
        check("full_q_empty",   32'(exp_q.size()), 32'd0);
        check("full_done",      32'(done), 32'd1);

        // Asynchronous reset after 4 bytes
        tb_xor = '0;
        pulse_load();
        send(8'h02); send(8'h00); send(8'h34); send(8'h12);
        byte_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("mid_rst_hold",  32'(cpu_hold), 32'd1);
        check("mid_rst_busy",  32'(busy), 32'd0);
        check("mid_rst_ready", 32'(byte_ready), 32'd0);
        check("mid_rst_done",  32'(done), 32'd0);
        check("mid_rst_addr",  32'(imem_addr), 32'd0);
        check("mid_rst_wdata", 32'(imem_wdata), 32'd0);
        tick();
        rst = 1'b1;
        tick(); tick();
        check("mid_rst_no_we", 32'(we_cnt), 32'd4100);

        // Recovery load (checksum trailer 01 when enabled)
        tb_xor = '0;
        pulse_load();
        send(8'h01); send(8'h00);
        push(12'd0, 8'h01, 8'h02, 8'h03);
        send(8'h01); send(8'h02); send(8'h03);
        send_csum();
        byte_valid = 1'b0;
        wait_start();
        check("rec_done",      32'(done), 32'd1);
        check("rec_start_cnt", 32'(start_cnt), 32'd5);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Wrong trailer byte
        tb_xor = '0;
        pulse_load();
        send(8'h01); send(8'h00);
        push(12'd0, 8'h01, 8'h02, 8'h03);
        send(8'h01); send(8'h02); send(8'h03);
        send(8'h00);
        byte_valid = 1'b0;
        tick(); tick();
        check("bad_csum_err",       32'(err), 32'd1);
        check("bad_csum_hold",      32'(cpu_hold), 32'd1);
        check("bad_csum_start_cnt", 32'(start_cnt), 32'd5);
`endif

        check("final_q_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
